step_dir_rx: RTL and testbench

STEP_DIR_RX -- requirements
Module: step_dir_rx

---
 rtl/step_pkg.sv | 16 +
 rtl/step_sync.sv | 47 ++++
 rtl/step_dir_rx.sv | 94 +++++++++
 tb/tb_step_dir_rx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/step_pkg.sv
// Shared constants and helpers for the step/direction receiver.
package step_pkg;

  localparam int DEF_PERIOD_CLKS = 10000;
  localparam int DEF_CNT_W       = 16;
  localparam int DDA_STEP_CLKS   = 80;

  // Two's complement to sign-magnitude; sign goes to bit w-1.
  function automatic logic [31:0] to_sign_mag(input logic signed [31:0] v, input int w);
    logic [31:0] r;
    r = v[31] ? -v : v;
    if (v[31]) r = r | (32'd1 << (w - 1));
    return r;
  endfunction

endpackage

// File: rtl/step_sync.sv
// 2-flop synchronizer, optional 3-sample majority filter, rising-edge detect.
// Filter is built in when STEP_RX_GLITCH_FILTER_EN is defined.
module step_sync #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], d};
  end

`ifdef STEP_RX_GLITCH_FILTER_EN
  logic [2:0] hist;

  always_ff @(posedge clk) begin
    if (!rst_n) hist <= '0;
    else        hist <= {hist[1:0], sync[1]};
  end

  // Combinational vote keeps the added latency at two cycles.
  assign level = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
  assign level = sync[1];
`endif

  generate
    if (EDGE_EN) begin : g_edge
      logic prev;
      always_ff @(posedge clk) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= level;
      end
      assign rise = level & ~prev;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/step_dir_rx.sv
// Step/direction receiver: counts signed steps per fixed window and latches
// the result as sign-magnitude. Optional input filter: STEP_RX_GLITCH_FILTER_EN.
module step_dir_rx
  import step_pkg::*;
#(
  parameter int PERIOD_CLKS = DEF_PERIOD_CLKS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse,
  input  logic             dir,
  input  logic             RD,
  output logic [CNT_W-1:0] N,
  output logic             valid,
  output logic             ovr,
  output logic             sat
);

  localparam int TMR_W = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD_CLKS - 1);
  localparam logic signed [CNT_W-1:0] ACC_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic signed [CNT_W-1:0] ACC_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] ACC_MIN = -ACC_MAX;

  logic step, dir_lvl, pulse_lvl_unused, dir_rise_unused;
  logic [TMR_W-1:0] timer;
  logic signed [CNT_W-1:0] acc, acc_nxt;
  logic win_sat, win_sat_nxt;
  logic tc;

  step_sync #(.EDGE_EN(1'b1)) u_pulse_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pulse),
    .level (pulse_lvl_unused),
    .rise  (step)
  );

  step_sync #(.EDGE_EN(1'b0)) u_dir_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dir),
    .level (dir_lvl),
    .rise  (dir_rise_unused)
  );

  assign tc = (timer == TMR_LAST);

  // A step landing on the latch cycle belongs to the window that starts next.
  always_comb begin
    acc_nxt     = acc;
    win_sat_nxt = win_sat;
    if (tc) begin
      win_sat_nxt = 1'b0;
      if (!step)        acc_nxt = '0;
      else if (dir_lvl) acc_nxt = -ACC_ONE;
      else              acc_nxt = ACC_ONE;
    end else if (step) begin
      if (!dir_lvl) begin
        if (acc == ACC_MAX) win_sat_nxt = 1'b1;
        else                acc_nxt = acc + ACC_ONE;
      end else begin
        if (acc == ACC_MIN) win_sat_nxt = 1'b1;
        else                acc_nxt = acc - ACC_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer   <= '0;
      acc     <= '0;
      win_sat <= 1'b0;
      N       <= '0;
      valid   <= 1'b0;
      ovr     <= 1'b0;
      sat     <= 1'b0;
    end else begin
      timer   <= tc ? '0 : timer + TMR_W'(1);
      acc     <= acc_nxt;
      win_sat <= win_sat_nxt;
      if (tc) begin
        N     <= CNT_W'(to_sign_mag(32'(acc), CNT_W));
        sat   <= win_sat;
        valid <= 1'b1;
        if (valid && !RD) ovr <= 1'b1;
      end else if (RD) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_step_dir_rx.sv
// Directed bench for step_dir_rx (16-bit and 8-bit instances, 4000-clk windows).
// Expectations adapt to STEP_RX_GLITCH_FILTER_EN.
module tb_step_dir_rx;
  import step_pkg::*;

  localparam int P = 4000;
`ifdef STEP_RX_GLITCH_FILTER_EN
  localparam int LAT        = 5;
  localparam int GLITCH_CNT = 0;
`else
  localparam int LAT        = 3;
  localparam int GLITCH_CNT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pulse = 1'b0, dir = 1'b0, rd = 1'b0;
  logic pulse8 = 1'b0, dir8 = 1'b0, rd8 = 1'b0;
  logic [15:0] n;
  logic valid, ovr, sat;
  logic [7:0] n8;
  logic valid8, ovr8, sat8;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  step_dir_rx #(.PERIOD_CLKS(P), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pulse(pulse), .dir(dir), .RD(rd),
    .N(n), .valid(valid), .ovr(ovr), .sat(sat)
  );

  step_dir_rx #(.PERIOD_CLKS(P), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .pulse(pulse8), .dir(dir8), .RD(rd8),
    .N(n8), .valid(valid8), .ovr(ovr8), .sat(sat8)
  );

  always #25 clk = ~clk;

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic goto_cyc(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < t) begin
      checks++;
      errors++;
      $display("FAIL goto_cyc got=%0d exp=%0d", cyc, t);
    end
  endtask

  task automatic send(input int cnt, input logic d, input int spacing, input bit ch8);
    for (int i = 0; i < cnt; i++) begin
      if (ch8) begin dir8 = d; pulse8 = 1'b1; end
      else     begin dir = d;  pulse = 1'b1;  end
      repeat (4) @(negedge clk);
      if (ch8) pulse8 = 1'b0;
      else     pulse = 1'b0;
      repeat (spacing - 4) @(negedge clk);
    end
  endtask

  task automatic glitch();
    pulse = 1'b1;
    @(negedge clk);
    pulse = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_n",     32'(n),     32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ovr",   32'(ovr),   32'h0);
    check("rst_sat",   32'(sat),   32'h0);
    rst_n = 1'b1;

    // window 1: 30 positive steps
    send(30, 1'b0, DDA_STEP_CLKS, 1'b0);
    goto_cyc(P - 1);
    check("w1_valid_early", 32'(valid), 32'h0);
    goto_cyc(P);
    check("w1_n",     32'(n),     32'h001E);
    check("w1_valid", 32'(valid), 32'h1);
    check("w1_sat",   32'(sat),   32'h0);
    check("w1_ovr",   32'(ovr),   32'h0);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("w1_rd_valid", 32'(valid), 32'h0);
    check("w1_rd_n",     32'(n),     32'h001E);

    // window 2: 30 negative steps
    send(30, 1'b1, DDA_STEP_CLKS, 1'b0);
    goto_cyc(2 * P);
    check("w2_n",     32'(n),     32'h801E);
    check("w2_valid", 32'(valid), 32'h1);
    check("w2_ovr",   32'(ovr),   32'h0);

    // window 3: no steps, RD coincident with the latch
    goto_cyc(3 * P - 1);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("w3_n",     32'(n),     32'h0);
    check("w3_valid", 32'(valid), 32'h1);
    check("w3_ovr",   32'(ovr),   32'h0);

    // window 4: step counted exactly on the latch edge, no RD -> overrun
    goto_cyc(4 * P - LAT);
    send(1, 1'b0, DDA_STEP_CLKS, 1'b0);
    check("w4_n",     32'(n),     32'h0);
    check("w4_valid", 32'(valid), 32'h1);
    check("w4_ovr",   32'(ovr),   32'h1);

    // window 5: seeded step shows up
    goto_cyc(5 * P);
    check("w5_n",   32'(n),   32'h1);
    check("w5_ovr", 32'(ovr), 32'h1);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("w5_rd_valid", 32'(valid), 32'h0);
    check("w5_rd_ovr",   32'(ovr),   32'h1);

    // window 6: step one cycle before the latch edge stays in this window
    goto_cyc(6 * P - LAT - 1);
    send(1, 1'b0, DDA_STEP_CLKS, 1'b0);
    check("w6_n", 32'(n), 32'h1);

    // window 7: single-cycle glitches plus real steps
    for (int i = 0; i < 5; i++) glitch();
    send(3, 1'b0, DDA_STEP_CLKS, 1'b0);
    goto_cyc(7 * P);
    check("w7_glitch_n", 32'(n), 32'(3 + 5 * GLITCH_CNT));

    // reset mid-window
    send(10, 1'b0, DDA_STEP_CLKS, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_n",      32'(n),      32'h0);
    check("mid_rst_valid",  32'(valid),  32'h0);
    check("mid_rst_ovr",    32'(ovr),    32'h0);
    check("mid_rst_sat",    32'(sat),    32'h0);
    check("mid_rst_n8",     32'(n8),     32'h0);
    check("mid_rst_valid8", 32'(valid8), 32'h0);
    check("mid_rst_ovr8",   32'(ovr8),   32'h0);
    rst_n = 1'b1;

    send(5, 1'b0, DDA_STEP_CLKS, 1'b0);
    send(200, 1'b0, 8, 1'b1);
    goto_cyc(P - 1);
    check("post_valid_early",  32'(valid),  32'h0);
    check("post_valid8_early", 32'(valid8), 32'h0);
    goto_cyc(P);
    check("post_n",      32'(n),      32'h5);
    check("post_valid",  32'(valid),  32'h1);
    check("post_ovr",    32'(ovr),    32'h0);
    check("post_sat",    32'(sat),    32'h0);
    check("sat8_n",      32'(n8),     32'h7F);
    check("sat8_sat",    32'(sat8),   32'h1);
    check("sat8_valid",  32'(valid8), 32'h1);
    check("sat8_ovr",    32'(ovr8),   32'h0);

    // negative saturation on the narrow instance
    send(200, 1'b1, 8, 1'b1);
    goto_cyc(2 * P);
    check("nsat8_n",   32'(n8),   32'hFF);
    check("nsat8_sat", 32'(sat8), 32'h1);
    check("nsat8_ovr", 32'(ovr8), 32'h1);
    check("post2_n",   32'(n),    32'h0);
    check("post2_ovr", 32'(ovr),  32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
